// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO: push/pop/flush with registered head; flush wins over a same-cycle push or pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             push_dat,
  output logic [$clog2(QDEPTH):0]  count,
  output fetch_entry_t             head
);

  localparam int AW = $clog2(QDEPTH);

  fetch_entry_t  slot_mem [QDEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is qualified by count.
  always_ff @(posedge clk) begin
    if (push && !flush) slot_mem[wr_ptr_q] <= push_dat;
  end

  assign count = count_q;
  assign head  = slot_mem[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, keeps at most one imem request in flight and buffers words in fetch_queue.
// Define FETCH_PERF_EN to add saturating perf_stall/perf_flush counters.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        pc_write,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [15:0] perf_flush
`endif
);

  localparam int CW = $clog2(QDEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [CW-1:0] count, count_after;
  logic          push, pop;
  fetch_entry_t  push_dat, head;

  assign pop         = if_valid && pc_write && !redirect_valid;
  assign count_after = pop ? count : count + CW'(1);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    push_dat   = '{instr: imem_rdata, pc: fetch_pc_q};
    case (state_q)
      IDLE: begin
        if (!redirect_valid && count < CW'(QDEPTH)) begin
          state_d = REQ;
          addr_d  = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          state_d = DRAIN;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + PC_INC;
          if (count_after < CW'(QDEPTH)) begin
            state_d = REQ;
            addr_d  = fetch_pc_d;
          end else begin
            state_d = IDLE;
          end
        end
      end
      // Old request stays on the bus at its original address until acked.
      DRAIN: begin
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) fetch_pc_d = align_word(redirect_addr);
    req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .push_dat (push_dat),
    .count    (count),
    .head     (head)
  );

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign if_valid  = (count != '0);
  assign if_instr  = if_valid ? head.instr : '0;
  assign if_pc     = if_valid ? head.pc : '0;
  assign if_pc4    = if_valid ? head.pc + PC_INC : '0;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (if_valid && !pc_write && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
    if (redirect_valid && perf_flush_q != '1)        perf_flush_d = perf_flush_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random redirect/stall/ack-latency traffic
// checked against an in-order program-stream model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          QDEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        pc_write;
  logic        if_valid;
  logic [31:0] if_instr, if_pc, if_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall;
  logic [15:0] perf_flush;
`endif

  instr_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .pc_write       (pc_write),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: the program stream is the PC sequence from the latest redirect target.
  logic [31:0] exp_pc;
  bit          post_redir;
  int          wait_cnt;
  bit          req_pend;
  logic [31:0] pend_addr;
  int          lat_min, lat_max;
  int          pops;
  logic [31:0] popped[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: check settled outputs, answer imem, drive inputs, advance the model.
  task automatic cycle(input bit redir, input logic [31:0] raddr, input bit pw);
    logic ack;
    if (post_redir) check("empty_after_redirect", if_valid, 1'b0);
    if (req_pend) begin
      check("req_held", imem_req, 1'b1);
      check("addr_held", imem_addr, pend_addr);
    end
    if (imem_req) check("addr_aligned", imem_addr[1:0], 2'b00);
    if (if_valid) begin
      check("head_pc", if_pc, exp_pc);
      check("head_instr", if_instr, word_at(exp_pc));
      check("head_pc4", if_pc4, exp_pc + 32'd4);
    end
    ack = 1'b0;
    if (imem_req) begin
      if (wait_cnt < 0) wait_cnt = $urandom_range(lat_max, lat_min);
      if (wait_cnt == 0) begin
        ack = 1'b1;
        wait_cnt = -1;
      end else begin
        wait_cnt--;
      end
    end else begin
      wait_cnt = -1;
    end
    imem_ack       = ack;
    imem_rdata     = ack ? word_at(imem_addr) : $urandom;
    req_pend       = imem_req && !ack;
    pend_addr      = imem_addr;
    redirect_valid = redir;
    redirect_addr  = raddr;
    pc_write       = pw;
    if (redir) begin
      exp_pc     = raddr & ~32'h3;
      post_redir = 1'b1;
    end else begin
      post_redir = 1'b0;
      if (if_valid && pw) begin
        popped.push_back(if_pc);
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    pc_write = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", if_valid, 1'b0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_instr", if_instr, 32'h0);
`ifdef FETCH_PERF_EN
    check("rst_perf_stall", perf_stall, 32'h0);
    check("rst_perf_flush", {16'h0, perf_flush}, 32'h0);
`endif
    rst = 1'b0;
    exp_pc = RESET_PC;
    post_redir = 1'b0;
    wait_cnt = -1;
    req_pend = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int lim);
    int n = 0;
    while (!if_valid && n < lim) begin
      cycle(1'b0, 32'h0, 1'b1);
      n++;
    end
    check(tag, if_valid, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, n;
    pops = 0;
    lat_min = 0;
    lat_max = 0;
    do_reset();

    // Reset release latency, then sequential fetch from RESET_PC.
    cycle(1'b0, 32'h0, 1'b1);
    check("lat_req", imem_req, 1'b1);
    check("lat_addr", imem_addr, RESET_PC);
    check("lat_valid_early", if_valid, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    check("lat_valid", if_valid, 1'b1);
    check("lat_pc", if_pc, RESET_PC);
    n = 0;
    while (popped.size() < 4 && n < 40) begin
      cycle(1'b0, 32'h0, 1'b1);
      n++;
    end
    for (int i = 0; i < 4; i++)
      check("seq_pc", (i < popped.size()) ? popped[i] : 32'hFFFF_FFFF, RESET_PC + 32'(4 * i));

    // Long stall fills the queue and stops requests; release drains exactly QDEPTH entries.
    repeat (10) cycle(1'b0, 32'h0, 1'b0);
    check("full_req_drop", imem_req, 1'b0);
    check("full_valid", if_valid, 1'b1);
    lat_min = 60;
    lat_max = 60;
    p0 = pops;
    n = 0;
    while (if_valid && n < 20) begin
      cycle(1'b0, 32'h0, 1'b1);
      n++;
    end
    check("drain_count", 32'(pops - p0), 32'(QDEPTH));

    // Redirect while a request is unacked; stale data must be discarded.
    lat_min = 3;
    lat_max = 3;
    wait_cnt = 3;
    check("pend_req", imem_req, 1'b1);
    cycle(1'b1, 32'h0000_0100, 1'b1);
    wait_valid("redir_unacked_valid", 40);
    check("redir_unacked_pc", if_pc, 32'h0000_0100);

    // Redirect with a same-cycle pop while entries are queued.
    lat_min = 0;
    lat_max = 0;
    repeat (4) cycle(1'b0, 32'h0, 1'b0);
    check("pre_flush_valid", if_valid, 1'b1);
    cycle(1'b1, 32'h0000_0040, 1'b1);
    check("flush_empty", if_valid, 1'b0);
    wait_valid("flush_refill", 40);
    check("flush_pc", if_pc, 32'h0000_0040);

    // Alignment of the redirect target, then wrap at the top of the address space.
    repeat (12) cycle(1'b0, 32'h0, 1'b0);
    check("align_idle", imem_req, 1'b0);
    cycle(1'b1, 32'h0000_0203, 1'b0);
    n = 0;
    while (!imem_req && n < 10) begin
      cycle(1'b0, 32'h0, 1'b0);
      n++;
    end
    check("align_req", imem_req, 1'b1);
    check("align_addr", imem_addr, 32'h0000_0200);
    wait_valid("align_valid", 20);
    check("align_pc", if_pc, 32'h0000_0200);
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
    wait_valid("wrap_valid", 20);
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", if_pc4, 32'h0000_0000);
    cycle(1'b0, 32'h0, 1'b1);
    wait_valid("wrap_next_valid", 20);
    check("wrap_next_pc", if_pc, 32'h0000_0000);

    // Random traffic: ack latency, stalls and redirects.
    lat_min = 0;
    lat_max = 3;
    p0 = pops;
    for (int i = 0; i < 800; i++) begin
      bit          rd;
      logic [31:0] ra;
      rd = ($urandom_range(99, 0) < 5);
      ra = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                        : 32'($urandom_range(4095, 0));
      cycle(rd, ra, $urandom_range(99, 0) < 70);
    end
    check("random_progress", 32'(pops - p0 > 100), 32'd1);

    // Reset in the middle of traffic, then recover.
    do_reset();
    for (int i = 0; i < 100; i++)
      cycle(($urandom_range(99, 0) < 4), 32'($urandom_range(1023, 0)), $urandom_range(99, 0) < 70);

`ifdef FETCH_PERF_EN
    do_reset();
    lat_min = 0;
    lat_max = 0;
    wait_valid("perf_valid", 20);
    repeat (5) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h0000_0080, 1'b1);
    cycle(1'b1, 32'h0000_0090, 1'b1);
    check("perf_stall", perf_stall, 32'd5);
    check("perf_flush", {16'h0, perf_flush}, 32'd2);
    do_reset();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
